// File: rtl/mul4_stream_stage_pkg.sv
// Shared widths, operand/product types and the full-adder cell used by the
// 4x4 array multiplier and its handshaked wrapper.
package mul4_stream_stage_pkg;

  localparam int MUL_W  = 4;
  localparam int PROD_W = 2 * MUL_W;

  typedef struct packed {
    logic [MUL_W-1:0] a;
    logic [MUL_W-1:0] b;
  } operand_t;

  typedef logic [PROD_W-1:0] product_t;

  // One full-adder cell: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/mul4_stream_stage_array.sv
// Combinational W x W unsigned array multiplier: AND partial products summed by
// ripple-carry rows of full-adder cells.
module mul4_array
  import mul4_stream_stage_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  // row[i] is the running sum after partial product i; its LSB is final.
  logic [W:0] row [W];

  assign row[0] = {1'b0, a & {W{b[0]}}};
  assign p[0]   = row[0][0];

  for (genvar i = 1; i < W; i++) begin : g_row
    logic [W-1:0] pp;
    logic [W-1:0] x;
    logic [W-1:0] s;
    logic [W:0]   c;

    assign pp   = a & {W{b[i]}};
    assign x    = row[i-1][W:1];
    assign c[0] = 1'b0;

    for (genvar j = 0; j < W; j++) begin : g_fa
      assign {c[j+1], s[j]} = full_add(x[j], pp[j], c[j]);
    end

    assign row[i] = {c[W], s};
    assign p[i]   = row[i][0];
  end

  assign p[2*W-1:W] = row[W-1][W:1];

endmodule

// File: rtl/mul4_stream_stage.sv
// Two-register valid/ready wrapper around the array multiplier with a
// completed-transaction counter. Full throughput, two-cycle latency.
module mul4_stream_stage
  import mul4_stream_stage_pkg::*;
#(
  parameter int W     = MUL_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic [CNT_W-1:0] done_cnt
);

  // Handshake: a beat transfers on any edge where valid & ready are both 1;
  // valid and its data hold steady until that edge, and ready may depend
  // combinationally on the downstream ready.
  logic           s1_valid;
  logic [W-1:0]   s1_a;
  logic [W-1:0]   s1_b;
  logic           s2_free;
  logic           s1_drain;
  logic [2*W-1:0] prod;

  assign s2_free  = !out_valid || out_ready;
  assign s1_drain = s1_valid && s2_free;
  assign in_ready = !s1_valid || s1_drain;

  mul4_array #(.W(W)) u_array (
    .a (s1_a),
    .b (s1_b),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      done_cnt  <= '0;
    end else begin
      if (in_valid && in_ready) begin
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_valid <= 1'b1;
      end else if (s1_drain) begin
        s1_valid <= 1'b0;
      end

      // Stage 2 only updates when its current word is gone or leaving now.
      if (s2_free) begin
        out_valid <= s1_valid;
        if (s1_valid) out_p <= prod;
      end

      if (out_valid && out_ready) done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mul4_stream_stage.sv
// Scoreboard bench for mul4_stream_stage: driver pushes a*b on acceptance,
// a negedge monitor pops and compares every completed output handshake.
module tb_mul4_stream_stage;

  localparam int W     = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*W-1:0]   out_p;
  logic [CNT_W-1:0] done_cnt;

  logic [2*W-1:0] exp_q[$];
  int  tests     = 0;
  int  fails     = 0;
  int  hs_total  = 0;
  int  stalls    = 0;
  int  ready_mode = 0;  // 0: always ready, 1: never ready, 2: random
  bit  chk_en    = 1'b0;
  bit  stall_prev = 1'b0;
  logic [2*W-1:0] stall_p = '0;

  mul4_stream_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .done_cnt  (done_cnt)
  );

  // Clock and consumer ready generation
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  task automatic check(input bit ok, input string name, input int act, input int exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (chk_en) begin
      check(int'(done_cnt) == hs_total % (1 << CNT_W), "done_cnt", int'(done_cnt),
            hs_total % (1 << CNT_W));
      if (rst) begin
        exp_q.delete();
        hs_total   = 0;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          check(out_valid && out_p == stall_p, "hold_stable", int'(out_p), int'(stall_p));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_output", int'(out_p), -1);
          end else begin
            logic [2*W-1:0] e;
            e = exp_q.pop_front();
            check(out_p == e, "product", int'(out_p), int'(e));
          end
          hs_total++;
        end
        stall_prev = out_valid && !out_ready;
        stall_p    = out_p;
      end
    end
  end

  // Driver tasks
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int tries = 0;
    bit done  = 1'b0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        exp_q.push_back((2*W)'(int'(a) * int'(b)));
        done = 1'b1;
      end else begin
        stalls++;
        tries++;
        if (tries > 200) begin
          check(1'b0, "accept_timeout", tries, 200);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    ready_mode = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    check(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
    check(int'(done_cnt) == 0, "reset_done_cnt", int'(done_cnt), 0);
    check(in_ready == 1'b1, "reset_in_ready", int'(in_ready), 1);
    check(int'(out_p) == 0, "reset_out_p", int'(out_p), 0);
    @(posedge clk);
    #1;

    // Single transaction and latency
    ready_mode = 0;
    send(4'd15, 4'd15);
    @(negedge clk);
    check(out_valid == 1'b0, "latency_early", int'(out_valid), 0);
    @(negedge clk);
    check(out_valid == 1'b1, "latency_valid", int'(out_valid), 1);
    check(int'(out_p) == 225, "single_225", int'(out_p), 225);
    @(negedge clk);
    check(int'(done_cnt) == 1, "single_done_cnt", int'(done_cnt), 1);
    @(posedge clk);
    #1;

    // Back-to-back at full throughput
    stalls = 0;
    send(4'd3, 4'd5);
    send(4'd0, 4'd9);
    send(4'd7, 4'd8);
    send(4'd15, 4'd1);
    check(stalls == 0, "b2b_no_stall", stalls, 0);
    drain();

    // Back-pressure
    ready_mode = 1;
    @(posedge clk);
    #1;
    send(4'd2, 4'd3);
    send(4'd4, 4'd4);
    @(negedge clk);
    check(in_ready == 1'b0, "bp_in_ready", int'(in_ready), 0);
    check(out_valid == 1'b1 && int'(out_p) == 6, "bp_out_p", int'(out_p), 6);
    @(posedge clk);
    #1;
    fork
      send(4'd6, 4'd7);
      begin
        repeat (4) @(posedge clk);
        #1;
        ready_mode = 0;
      end
    join
    drain();

    // Reset mid-flight: 81 must never surface
    send(4'd9, 4'd9);
    pulse_reset();
    @(negedge clk);
    check(out_valid == 1'b0, "midrst_out_valid", int'(out_valid), 0);
    check(int'(done_cnt) == 0, "midrst_done_cnt", int'(done_cnt), 0);
    check(in_ready == 1'b1, "midrst_in_ready", int'(in_ready), 1);
    repeat (5) @(posedge clk);
    #1;

    // Counter wrap: 9 transactions on a 3-bit counter
    for (int i = 0; i < 9; i++) send(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    drain();
    check(int'(done_cnt) == 1, "wrap_done_cnt", int'(done_cnt), 1);

    // Exhaustive operand pairs with random consumer stalls and source gaps
    pulse_reset();
    ready_mode = 2;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        send(W'(a), W'(b));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drain();
    check(int'(done_cnt) == 256 % (1 << CNT_W), "exh_done_cnt", int'(done_cnt),
          256 % (1 << CNT_W));
    check(hs_total == 256, "exh_total", hs_total, 256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul4_stream_stage.md
Name: mul4_stream_stage

Overview:
- Handshaked pipeline wrapper that feeds the 4-bit parallel array multiplier and consumes its product.
- Upstream register captures the operand pair. The combinational full-adder array forms the product. The downstream register holds the product until the consumer accepts it.
- Sits between the operand source (test driver / control FSM) and the result consumer.
- Full throughput: one product per clock when unstalled.

Parameters:
- W, 4: operand width in bits. Product width is 2*W.
- CNT_W, 8: width of the completed-transaction counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept an operand pair this cycle
- in_a  input  W  multiplicand, unsigned
- in_b  input  W  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts the product this cycle
- out_p  output  2*W  product in_a*in_b, unsigned
- done_cnt  output  CNT_W  count of accepted products; wraps modulo 2^CNT_W

Behaviour:
- Reset and clocking:
  - One clock, clk. Reset rst is synchronous and active-high.
  - While rst=1 at a clock edge: s1_valid=0, out_valid=0, out_p=0, done_cnt=0, s1_a=0, s1_b=0.
  - in_ready is combinational and equals 1 during and after reset, because stage 1 is empty.
- Stage 1 (operand register): holds s1_a, s1_b, s1_valid.
- Stage 2 (result register): holds out_p and out_valid.
- Handshake terms:
  - s2_free = !out_valid | out_ready.
  - s1_drain = s1_valid & s2_free.
  - in_ready = !s1_valid | s1_drain. This is a combinational ready chain; no bubble is required.
- Input transfer: when in_valid & in_ready, the edge loads s1_a<=in_a, s1_b<=in_b, s1_valid<=1.
  - Else if s1_drain, s1_valid<=0.
  - Else stage 1 holds.
- Output load: when s2_free, the edge sets out_valid<=s1_valid. If s1_valid, out_p<=mul4_array(s1_a, s1_b).
  - When !s2_free, out_valid and out_p hold. They stay stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles. Operands accepted at edge N appear on out_p/out_valid after edge N+1.
- Counter: done_cnt increments by 1 at every edge where out_valid & out_ready. It wraps from 2^CNT_W-1 to 0 with no flag.
- Simultaneous events:
  - Accept plus drain in the same cycle: stage 1 reloads, stage 2 reloads, and no data is lost.
  - out_ready=1 with out_valid=0 has no effect.
- Arithmetic:
  - Unsigned only. The product is exact in 2*W bits; overflow is impossible.
  - out_p must equal in_a*in_b bit-exact for all 2^(2W) operand pairs.
- Reset mid-operation: all in-flight data is discarded, and no output handshake completes on the reset edge. The first product after reset requires new input.
- Protocol rules:
  - in_a/in_b are don't-care when in_valid=0.
  - The producer must not drop in_valid before acceptance. The block does not check this.
- No state machine beyond the two valid bits. The four legal states {s1_valid,out_valid} = 00, 10, 01, 11 are all reachable.

Decomposition:
- Shared package holds:
  - constants MUL_W=4 and PROD_W=8
  - a typedef for the operand pair (a,b)
  - a typedef for the product word, shared with the consumer.
- Natural sub-module: mul4_array, the combinational W×W array multiplier. It is built from the existing full-adder cell rows (AND partial products plus ripple rows) and instantiated once between the stages.
- All registers and handshake logic live in the top module.

Test Plan:
- Reset and single transaction: after reset, out_valid=0, done_cnt=0, in_ready=1. Drive a=15, b=15 for one cycle with out_ready=1. Expect out_p=225 (0xE1), out_valid=1 exactly 2 edges after acceptance, then done_cnt=1.
- Back-to-back: stream (3,5),(0,9),(7,8),(15,1) on consecutive cycles with out_ready=1. Expect out_p=15,0,56,15 on consecutive cycles and in_ready constantly 1.
- Back-pressure: hold out_ready=0 while streaming (2,3),(4,4),(6,7).
  - Expect out_p=6 stable and in_ready=0 after the second accept.
  - Release out_ready: products 6,16,42 arrive in order with none lost or duplicated.
- Reset mid-flight: accept (9,9), assert rst on the next edge. Expect out_valid=0 and done_cnt=0 afterward, and product 81 never appears.
- Counter wrap (CNT_W=3): complete 9 transactions. Expect done_cnt sequence 1..7,0,1.
- Exhaustive: all 256 operand pairs with random out_ready. Every out_p matches a*b in order, and done_cnt equals 256 mod 2^CNT_W.
